// File: rtl/uart_pkg.sv
// Shared UART constants: baud rates, baud_set encodings, transmitter FSM states
// and the bit-period helper used to size the baud divider.
package uart_pkg;

    localparam int DIV_W = 16;
    localparam int unsigned DEFAULT_CLK_HZ = 32'd50000000;

    localparam int unsigned BAUD_9600   = 32'd9600;
    localparam int unsigned BAUD_19200  = 32'd19200;
    localparam int unsigned BAUD_38400  = 32'd38400;
    localparam int unsigned BAUD_57600  = 32'd57600;
    localparam int unsigned BAUD_115200 = 32'd115200;
    localparam int unsigned BAUD_230400 = 32'd230400;

    localparam logic [2:0] BAUD_SEL_9600   = 3'd0;
    localparam logic [2:0] BAUD_SEL_19200  = 3'd1;
    localparam logic [2:0] BAUD_SEL_38400  = 3'd2;
    localparam logic [2:0] BAUD_SEL_57600  = 3'd3;
    localparam logic [2:0] BAUD_SEL_115200 = 3'd4;
    localparam logic [2:0] BAUD_SEL_230400 = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Unlisted encodings (6, 7) fall back to the slowest rate.
    function automatic int unsigned baud_rate(input logic [2:0] sel);
        case (sel)
            BAUD_SEL_9600:   baud_rate = BAUD_9600;
            BAUD_SEL_19200:  baud_rate = BAUD_19200;
            BAUD_SEL_38400:  baud_rate = BAUD_38400;
            BAUD_SEL_57600:  baud_rate = BAUD_57600;
            BAUD_SEL_115200: baud_rate = BAUD_115200;
            BAUD_SEL_230400: baud_rate = BAUD_230400;
            default:         baud_rate = BAUD_9600;
        endcase
    endfunction

    function automatic logic [DIV_W-1:0] bit_period(input int unsigned clk_hz,
                                                    input logic [2:0] sel);
        bit_period = 16'(clk_hz / baud_rate(sel));
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: counts 0..div-1 while enabled and flags the last clock
// of each bit so the transmitter can advance on the following edge.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_r;
    logic             last_s;

    // Bit boundary decode from the registered count.
    always_comb begin
        last_s = (cnt_r == (div - 16'd1));
        tick   = en && last_s;
    end

    // Counter held at zero while idle so every frame starts on a fresh bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 16'd0;
        end else if (!en) begin
            cnt_r <= 16'd0;
        end else if (last_s) begin
            cnt_r <= 16'd0;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter with valid/ready request port and selectable baud rate;
// the line, busy, ready and done outputs all come straight from registers.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_set,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [DIV_W-1:0] DIV_9600   = bit_period(CLK_HZ, BAUD_SEL_9600);
    localparam logic [DIV_W-1:0] DIV_19200  = bit_period(CLK_HZ, BAUD_SEL_19200);
    localparam logic [DIV_W-1:0] DIV_38400  = bit_period(CLK_HZ, BAUD_SEL_38400);
    localparam logic [DIV_W-1:0] DIV_57600  = bit_period(CLK_HZ, BAUD_SEL_57600);
    localparam logic [DIV_W-1:0] DIV_115200 = bit_period(CLK_HZ, BAUD_SEL_115200);
    localparam logic [DIV_W-1:0] DIV_230400 = bit_period(CLK_HZ, BAUD_SEL_230400);

    tx_state_e        state_r;
    logic [7:0]       data_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_sel_s;
    logic [2:0]       bit_idx_r;
    logic             uart_tx_r;
    logic             busy_r;
    logic             done_r;
    logic             ready_r;
    logic             accept_s;
    logic             tick_s;

    // Constant divider lookup; only the chosen entry is latched at acceptance.
    always_comb begin
        case (baud_set)
            BAUD_SEL_9600:   div_sel_s = DIV_9600;
            BAUD_SEL_19200:  div_sel_s = DIV_19200;
            BAUD_SEL_38400:  div_sel_s = DIV_38400;
            BAUD_SEL_57600:  div_sel_s = DIV_57600;
            BAUD_SEL_115200: div_sel_s = DIV_115200;
            BAUD_SEL_230400: div_sel_s = DIV_230400;
            default:         div_sel_s = DIV_9600;
        endcase
        accept_s = tx_valid && ready_r;
    end

    uart_baud_gen u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .en    (busy_r),
        .div   (div_r),
        .tick  (tick_s)
    );

    // Frame sequencer; ready is a register so it stays low for the first
    // clock after reset and tracks the IDLE state thereafter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            data_r    <= 8'd0;
            div_r     <= 16'd0;
            bit_idx_r <= 3'd0;
            uart_tx_r <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ready_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r   <= ST_START;
                        data_r    <= tx_data;
                        div_r     <= div_sel_s;
                        bit_idx_r <= 3'd0;
                        uart_tx_r <= 1'b0;
                        busy_r    <= 1'b1;
                        ready_r   <= 1'b0;
                    end else begin
                        uart_tx_r <= 1'b1;
                        busy_r    <= 1'b0;
                        ready_r   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        state_r   <= ST_DATA;
                        bit_idx_r <= 3'd0;
                        uart_tx_r <= data_r[0];
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (bit_idx_r == 3'd7) begin
                            state_r   <= ST_STOP;
                            uart_tx_r <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            uart_tx_r <= data_r[bit_idx_r + 3'd1];
                        end
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        state_r   <= ST_IDLE;
                        uart_tx_r <= 1'b1;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        ready_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    uart_tx_r <= 1'b1;
                    busy_r    <= 1'b0;
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

    assign uart_tx  = uart_tx_r;
    assign tx_busy  = busy_r;
    assign tx_done  = done_r;
    assign tx_ready = ready_r;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: a scaled-clock instance for most frames
// and a default 50 MHz instance for the full-rate bit periods.
module tb_uart_byte_tx;

    localparam int unsigned CLK_S = 32'd1152000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] baud_set = 3'd0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       use50 = 1'b0;

    logic va, vb;
    logic rdy_a, tx_a, busy_a, done_a;
    logic rdy_b, tx_b, busy_b, done_b;
    logic o_ready, o_tx, o_busy, o_done;

    assign va      = tx_valid & ~use50;
    assign vb      = tx_valid & use50;
    assign o_ready = use50 ? rdy_b  : rdy_a;
    assign o_tx    = use50 ? tx_b   : tx_a;
    assign o_busy  = use50 ? busy_b : busy_a;
    assign o_done  = use50 ? done_b : done_a;

    uart_byte_tx #(.CLK_HZ(CLK_S)) dut (
        .clk(clk), .reset(reset), .baud_set(baud_set), .tx_data(tx_data),
        .tx_valid(va), .tx_ready(rdy_a), .uart_tx(tx_a), .tx_busy(busy_a), .tx_done(done_a)
    );

    uart_byte_tx dut50 (
        .clk(clk), .reset(reset), .baud_set(baud_set), .tx_data(tx_data),
        .tx_valid(vb), .tx_ready(rdy_b), .uart_tx(tx_b), .tx_busy(busy_b), .tx_done(done_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         big;
        logic [2:0] sel;
        logic [7:0] data;
        int         div;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int baud_of(input int sel);
        case (sel)
            0: return 9600;
            1: return 19200;
            2: return 38400;
            3: return 57600;
            4: return 115200;
            5: return 230400;
            default: return 9600;
        endcase
    endfunction

    // Expected line level k clocks after acceptance: start, 8 data bits LSB first, stop.
    function automatic int line_bit(input logic [7:0] d, input int k, input int div);
        int idx;
        idx = k / div;
        if (idx == 0) return 0;
        if (idx >= 9) return 1;
        return int'(d[idx-1]);
    endfunction

    function automatic int zeros(input logic [7:0] d);
        int n = 0;
        for (int i = 0; i < 8; i++) if (d[i] == 1'b0) n++;
        return n;
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_frame(input logic [7:0] d, input logic [2:0] sel, input bit keep,
                               output int acc_cyc);
        int w = 0;
        while (o_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("ready_timeout", 0, 1);
        tx_data  = d;
        baud_set = sel;
        tx_valid = 1'b1;
        @(negedge clk);
        acc_cyc = cyc;
        if (!keep) tx_valid = 1'b0;
    endtask

    // mode 0 quiet, 1 random input noise, 2 switch baud/data mid-frame, 3 hold valid
    task automatic run_frame(input logic [7:0] d, input int div, input int mode,
                             output int done_cyc);
        int bad = 0;
        int first_k = -1;
        logic [3:0] first_got = 4'd0;
        int lows = 0;
        for (int k = 0; k < 10 * div; k++) begin
            int e;
            e = line_bit(d, k, div);
            if (o_tx === 1'b0) lows++;
            if (o_tx !== e[0] || o_busy !== 1'b1 || o_ready !== 1'b0 || o_done !== 1'b0) begin
                bad++;
                if (first_k < 0) begin
                    first_k   = k;
                    first_got = {o_tx, o_busy, o_ready, o_done};
                end
            end
            case (mode)
                1: begin
                    baud_set = 3'($urandom_range(7, 0));
                    tx_data  = 8'($urandom);
                    tx_valid = 1'($urandom_range(1, 0));
                end
                2: begin
                    if (k == div / 2) begin
                        baud_set = 3'd0;
                        tx_data  = ~d;
                    end
                end
                default: ;
            endcase
            @(negedge clk);
        end
        if (bad != 0)
            $display("frame detail: data=%h first bad k=%0d tx/busy/ready/done=%b want tx=%0d busy=1 ready=0 done=0",
                     d, first_k, first_got, line_bit(d, first_k, div));
        chk("frame_wave", bad, 0);
        chk("low_cycles", lows, div * (1 + zeros(d)));
        done_cyc = cyc;
        chk("done_pulse", int'(o_done), 1);
        chk("done_ready", int'(o_ready), 1);
        chk("done_busy", int'(o_busy), 0);
        chk("done_line", int'(o_tx), 1);
        if (mode != 3) tx_valid = 1'b0;
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        chk(name, int'({o_done, o_busy, o_tx, o_ready}), 4'b0011);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, dc, dc2, dones;
        logic [7:0] d;
        int sel;

        tbl[0] = '{1'b1, 3'd4, 8'h55, 434};
        tbl[1] = '{1'b1, 3'd5, 8'hC3, 217};
        tbl[2] = '{1'b0, 3'd0, 8'h5A, 120};
        tbl[3] = '{1'b0, 3'd1, 8'h81, 60};
        tbl[4] = '{1'b0, 3'd2, 8'h0F, 30};
        tbl[5] = '{1'b0, 3'd3, 8'hF0, 20};
        tbl[6] = '{1'b0, 3'd4, 8'h55, 10};
        tbl[7] = '{1'b0, 3'd5, 8'hA5, 5};
        tbl[8] = '{1'b0, 3'd6, 8'h3C, 120};
        tbl[9] = '{1'b0, 3'd7, 8'h00, 120};

        // Reset state on both instances
        #12;
        chk("rst_state_a", int'({tx_a, busy_a, done_a, rdy_a}), 4'b1000);
        chk("rst_state_b", int'({tx_b, busy_b, done_b, rdy_b}), 4'b1000);
        @(negedge clk);
        reset = 1'b0;
        chk("ready_low_at_release", int'(rdy_a), 0);
        @(negedge clk);
        chk("ready_first_clock", int'(rdy_a), 1);
        chk("ready_first_clock_50", int'(rdy_b), 1);

        // Table of single frames across all baud selections
        for (int i = 0; i < 10; i++) begin
            use50 = tbl[i].big;
            start_frame(tbl[i].data, tbl[i].sel, 1'b0, acc);
            run_frame(tbl[i].data, tbl[i].div, 0, dc);
            chk("done_latency", dc - acc, 10 * tbl[i].div);
            idle_check("idle_after_frame");
            use50 = 1'b0;
        end

        // Held valid: second frame starts right after the first frame's done cycle
        start_frame(8'hA5, 3'd4, 1'b1, acc);
        tx_data = 8'h3C;
        run_frame(8'hA5, 10, 3, dc);
        @(negedge clk);
        tx_valid = 1'b0;
        run_frame(8'h3C, 10, 0, dc2);
        chk("b2b_done_spacing", dc2 - dc, 10 * 10 + 1);
        idle_check("idle_after_b2b");

        // Mid-frame baud/data change is ignored; next frame uses the new baud
        start_frame(8'h96, 3'd4, 1'b0, acc);
        run_frame(8'h96, 10, 2, dc);
        chk("midchange_latency", dc - acc, 100);
        idle_check("idle_after_midchange");
        start_frame(8'h69, 3'd0, 1'b0, acc);
        run_frame(8'h69, 120, 0, dc);
        chk("slow_after_change_latency", dc - acc, 1200);

        // Reset during data bit 3 aborts at once, then a normal frame follows
        start_frame(8'h5A, 3'd4, 1'b0, acc);
        for (int k = 0; k < 44; k++) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("abort_state", int'({tx_a, busy_a, done_a, rdy_a}), 4'b1000);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        @(negedge clk);
        chk("ready_after_abort", int'(rdy_a), 1);
        for (int k = 0; k < 15; k++) begin
            if (done_a === 1'b1 || tx_a !== 1'b1) dones++;
            @(negedge clk);
        end
        chk("no_done_after_abort", dones, 0);
        start_frame(8'hFF, 3'd4, 1'b0, acc);
        run_frame(8'hFF, 10, 0, dc);
        chk("post_abort_latency", dc - acc, 100);
        idle_check("idle_after_abort_frame");

        // Random frames with input noise while busy, against the reference model
        for (int i = 0; i < 12; i++) begin
            sel = int'($urandom_range(7, 0));
            d   = 8'($urandom);
            start_frame(d, 3'(sel), 1'b0, acc);
            run_frame(d, int'(CLK_S) / baud_of(sel), 1, dc);
            chk("rand_latency", dc - acc, 10 * (int'(CLK_S) / baud_of(sel)));
            idle_check("rand_no_extra_frame");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
